fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage. Owns the fetch PC and drives a ready/valid handshake to instruction memory. Delivers one instruction per cycle into a single-entry output slot that the decode stage drains. Handles back-pressure (stall), branch/jump redirects including squash of an in-flight request, and halt on the syscall word. Sits between the instruction memory and the IF/ID boundary, replacing free-running PC update logic.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_perf_counter.sv | 17 +
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] SYSCALL_HALT = 32'h0000_000C;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALT   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Ready/valid request channel between the fetch sequencer and instruction memory.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [INST_W-1:0] imem_addr;
    logic              imem_ready;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_perf_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, talks to imem, and fills a
// single-entry slot that decode drains; handles stall, redirect/squash and halt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    fetch_ctrl_if.master      imem,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] pc,
    output logic [INST_W-1:0] pc4,
    output logic              inst_valid,
    output logic              halted,
    output logic [31:0]       wait_cycles
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] fetch_pc_p0, fetch_pc_d;
    logic [INST_W-1:0] squash_pc_q, squash_pc_d;
    logic              req_pending_q, req_pending_d;
    logic [INST_W-1:0] inst_p1, inst_d;
    logic [INST_W-1:0] pc_p1, pc_d;
    logic              vld_p1, vld_d;

    logic req;
    logic accept;
    logic consume;

    // A pending request keeps req asserted so the address cannot move under memory.
    assign req     = (state_q == SQUASH) ||
                     ((state_q == RUN) && (req_pending_q || !vld_p1 || !stall));
    assign accept  = req && imem.imem_ready;
    assign consume = vld_p1 && !stall;

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_p0;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_p0;
        squash_pc_d   = squash_pc_q;
        req_pending_d = req && !imem.imem_ready;
        inst_d        = inst_p1;
        pc_d          = pc_p1;
        vld_d         = vld_p1;

        if (consume) begin
            vld_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (redirect) begin
                    vld_d = 1'b0;
                    if (accept) begin
                        fetch_pc_d = redirect_pc;
                    end else if (req) begin
                        squash_pc_d = redirect_pc;
                        state_d     = SQUASH;
                    end else begin
                        fetch_pc_d = redirect_pc;
                    end
                end else if (accept) begin
                    inst_d     = imem.imem_rdata;
                    pc_d       = fetch_pc_p0;
                    vld_d      = 1'b1;
                    fetch_pc_d = fetch_pc_p0 + 32'd4;
                    if (imem.imem_rdata == SYSCALL_HALT) begin
                        state_d = HALT;
                    end
                end
            end
            SQUASH: begin
                // The wrong-path response is discarded; the newest target is kept.
                if (redirect) begin
                    squash_pc_d = redirect_pc;
                    vld_d       = 1'b0;
                end
                if (imem.imem_ready) begin
                    fetch_pc_d = redirect ? redirect_pc : squash_pc_q;
                    state_d    = RUN;
                end
            end
            HALT: begin
                if (redirect) begin
                    vld_d      = 1'b0;
                    fetch_pc_d = redirect_pc;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Stage p0: fetch control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_p0   <= RESET_PC;
            squash_pc_q   <= RESET_PC;
            req_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_p0   <= fetch_pc_d;
            squash_pc_q   <= squash_pc_d;
            req_pending_q <= req_pending_d;
        end
    end

    // Stage p1: IF/ID output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_p1 <= '0;
            pc_p1   <= RESET_PC;
            vld_p1  <= 1'b0;
        end else begin
            inst_p1 <= inst_d;
            pc_p1   <= pc_d;
            vld_p1  <= vld_d;
        end
    end

    assign inst       = inst_p1;
    assign pc         = pc_p1;
    assign pc4        = pc_p1 + 32'd4;
    assign inst_valid = vld_p1;
    assign halted     = (state_q == HALT);

    fetch_perf_counter u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (req && !imem.imem_ready),
        .count (wait_cycles)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, wait states, stall, squash, halt, wrap, async reset.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] halt_addr;

    logic [31:0] inst, pc, pc4, wait_cycles;
    logic        inst_valid, halted;
    logic [31:0] inst2, pc2, pc42, wait2;
    logic        vld2, halted2;

    int vectors;
    int miscompares;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    // Memory model: word = address | 1, except the syscall word at halt_addr.
    assign bus.imem_ready  = ready;
    assign bus.imem_rdata  = (bus.imem_addr == halt_addr) ? SYSCALL_HALT : (bus.imem_addr | 32'd1);
    assign bus2.imem_ready = ready;
    assign bus2.imem_rdata = (bus2.imem_addr == halt_addr) ? SYSCALL_HALT : (bus2.imem_addr | 32'd1);

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(bus), .inst(inst), .pc(pc), .pc4(pc4), .inst_valid(inst_valid),
        .halted(halted), .wait_cycles(wait_cycles)
    );

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(bus2), .inst(inst2), .pc(pc2), .pc4(pc42), .inst_valid(vld2),
        .halted(halted2), .wait_cycles(wait2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; ready = rdy; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        vectors++; if (pc4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc4: got %h want %h", pc4, 32'h4); end
        vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (wait_cycles !== 32'h0) begin miscompares++; $display("FAIL reset_wait: got %0d want 0", wait_cycles); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_addr: got %h want %h", bus.imem_addr, 32'h0); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            e = 32'(i * 4);
            vectors++; if (pc !== e) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc, e); end
            vectors++; if (inst !== (e | 32'd1)) begin miscompares++; $display("FAIL stream_inst[%0d]: got %h want %h", i, inst, e | 32'd1); end
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", i, inst_valid); end
        end
        vectors++; if (wait_cycles !== 32'h0) begin miscompares++; $display("FAIL stream_wait: got %0d want 0", wait_cycles); end
    endtask

    task automatic test_wait_then_stall();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL wait_req[%0d]: got %b want 1", i, bus.imem_req); end
            vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL wait_addr[%0d]: got %h want 0", i, bus.imem_addr); end
            tick();
        end
        vectors++; if (wait_cycles !== 32'd3) begin miscompares++; $display("FAIL wait_count: got %0d want 3", wait_cycles); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL wait_valid_early: got %b want 0", inst_valid); end
        ready = 1'b1;
        tick();
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL wait_valid: got %b want 1", inst_valid); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wait_pc: got %h want 0", pc); end
        // Issue a request to 0x4 that is held, then stall: req must stay up until ready.
        ready = 1'b0;
        tick();
        stall = 1'b1;
        #1;
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_pending_req: got %b want 1", bus.imem_req); end
        vectors++; if (bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL stall_pending_addr: got %h want 4", bus.imem_addr); end
        ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b want 0", i, bus.imem_req); end
            vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h want 4", i, pc); end
            vectors++; if (inst !== 32'h5) begin miscompares++; $display("FAIL stall_inst[%0d]: got %h want 5", i, inst); end
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, inst_valid); end
            tick();
        end
        stall = 1'b0;
        tick();
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL unstall_pc: got %h want 8", pc); end
        vectors++; if (wait_cycles !== 32'd4) begin miscompares++; $display("FAIL unstall_wait: got %0d want 4", wait_cycles); end
    endtask

    task automatic test_squash();
        do_reset(1'b1);
        tick();
        tick();
        ready = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL squash_req: got %b want 1", bus.imem_req); end
        vectors++; if (bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL squash_addr: got %h want 8", bus.imem_addr); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL squash_flush: got %b want 0", inst_valid); end
        tick();
        vectors++; if (bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL squash_hold: got %h want 8", bus.imem_addr); end
        ready = 1'b1;
        tick();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL squash_drop: got %b want 0", inst_valid); end
        vectors++; if (bus.imem_addr !== 32'h40) begin miscompares++; $display("FAIL squash_target: got %h want 40", bus.imem_addr); end
        tick();
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL squash_pc: got %h want 40", pc); end
        vectors++; if (inst !== 32'h41) begin miscompares++; $display("FAIL squash_inst: got %h want 41", inst); end
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL squash_valid: got %b want 1", inst_valid); end
    endtask

    task automatic test_halt();
        halt_addr = 32'h10;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early: got %b want 0", halted); end
        tick();
        vectors++; if (inst !== 32'hC) begin miscompares++; $display("FAIL halt_inst: got %h want c", inst); end
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL halt_pc: got %h want 10", pc); end
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL halt_valid: got %b want 1", inst_valid); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %b want 1", halted); end
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_req: got %b want 0", bus.imem_req); end
        tick();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL halt_drain: got %b want 0", inst_valid); end
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_req2: got %b want 0", bus.imem_req); end
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL unhalt_flag: got %b want 0", halted); end
        vectors++; if (bus.imem_addr !== 32'h20) begin miscompares++; $display("FAIL unhalt_addr: got %h want 20", bus.imem_addr); end
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL unhalt_req: got %b want 1", bus.imem_req); end
        halt_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick();
        stall = 1'b1;
        #1;
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL idle_redir_flush: got %b want 0", inst_valid); end
        vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL idle_redir_addr: got %h want fffffffc", bus.imem_addr); end
        stall = 1'b0;
        tick();
        vectors++; if (pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc: got %h want fffffffc", pc); end
        vectors++; if (pc4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4: got %h want 0", pc4); end
        vectors++; if (inst !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL wrap_inst: got %h want fffffffd", inst); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 0", bus.imem_addr); end
        tick();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wrap_next_pc: got %h want 0", pc); end
    endtask

    task automatic test_rst_mid();
        do_reset(1'b1);
        tick();
        tick();
        ready = 1'b0;
        tick();
        tick();
        vectors++; if (wait_cycles !== 32'd2) begin miscompares++; $display("FAIL mid_wait: got %0d want 2", wait_cycles); end
        rst = 1'b1;
        #1;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL mid_rst_pc: got %h want 0", pc); end
        vectors++; if (pc4 !== 32'h4) begin miscompares++; $display("FAIL mid_rst_pc4: got %h want 4", pc4); end
        vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL mid_rst_inst: got %h want 0", inst); end
        vectors++; if (wait_cycles !== 32'h0) begin miscompares++; $display("FAIL mid_rst_wait: got %0d want 0", wait_cycles); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst_addr: got %h want 0", bus.imem_addr); end
        vectors++; if (pc2 !== 32'h100) begin miscompares++; $display("FAIL mid_rst_pc_ovr: got %h want 100", pc2); end
        vectors++; if (pc42 !== 32'h104) begin miscompares++; $display("FAIL mid_rst_pc4_ovr: got %h want 104", pc42); end
        vectors++; if (vld2 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid_ovr: got %b want 0", vld2); end
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (bus2.imem_req !== 1'b1) begin miscompares++; $display("FAIL ovr_req: got %b want 1", bus2.imem_req); end
        vectors++; if (bus2.imem_addr !== 32'h100) begin miscompares++; $display("FAIL ovr_addr: got %h want 100", bus2.imem_addr); end
        vectors++; if (wait2 !== 32'h0) begin miscompares++; $display("FAIL ovr_wait0: got %0d want 0", wait2); end
        tick();
        vectors++; if (wait2 !== 32'd1) begin miscompares++; $display("FAIL ovr_wait1: got %0d want 1", wait2); end
        ready = 1'b1;
        tick();
        vectors++; if (pc2 !== 32'h100) begin miscompares++; $display("FAIL ovr_pc: got %h want 100", pc2); end
        vectors++; if (inst2 !== 32'h101) begin miscompares++; $display("FAIL ovr_inst: got %h want 101", inst2); end
        vectors++; if (vld2 !== 1'b1) begin miscompares++; $display("FAIL ovr_valid: got %b want 1", vld2); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        halt_addr = 32'hFFFF_FFF0;
        test_reset();
        test_stream();
        test_wait_then_stall();
        test_squash();
        test_halt();
        test_wrap();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
